// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the fetch/LSU memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [2:0] {
        LSF_LB  = 3'd0,
        LSF_LH  = 3'd1,
        LSF_LW  = 3'd2,
        LSF_LBU = 3'd3,
        LSF_LHU = 3'd4,
        LSF_SB  = 3'd5,
        LSF_SH  = 3'd6,
        LSF_SW  = 3'd7
    } load_store_func_code;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LSU  = 2'd2
    } arb_owner_e;

    // Fetches are always full-word reads, so the word code doubles as the idle value.
    localparam load_store_func_code LSF_DEFAULT = LSF_LW;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, LSU and DRAM handshake bundle for the arbiter
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                if_req_ip;
    logic [ADDR_W-1:0]   if_addr_ip;
    logic                if_gnt_op;
    logic                if_rvalid_op;
    logic [DATA_W-1:0]   if_rdata_op;
    logic                flush_ip;

    logic                lsu_req_ip;
    logic                lsu_we_ip;
    load_store_func_code lsu_operator_ip;
    logic [ADDR_W-1:0]   lsu_addr_ip;
    logic [DATA_W-1:0]   lsu_wdata_ip;
    logic                lsu_gnt_op;
    logic                lsu_rvalid_op;
    logic [DATA_W-1:0]   lsu_rdata_op;

    logic                mem_req_op;
    logic                mem_we_op;
    load_store_func_code mem_operator_op;
    logic [ADDR_W-1:0]   mem_addr_op;
    logic [DATA_W-1:0]   mem_wdata_op;
    logic                mem_gnt_ip;
    logic                mem_rvalid_ip;
    logic [DATA_W-1:0]   mem_rdata_ip;

    modport slave (
        input  if_req_ip, if_addr_ip, flush_ip,
        input  lsu_req_ip, lsu_we_ip, lsu_operator_ip, lsu_addr_ip, lsu_wdata_ip,
        input  mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
        output if_gnt_op, if_rvalid_op, if_rdata_op,
        output lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op,
        output mem_req_op, mem_we_op, mem_operator_op, mem_addr_op, mem_wdata_op
    );

    modport master (
        output if_req_ip, if_addr_ip, flush_ip,
        output lsu_req_ip, lsu_we_ip, lsu_operator_ip, lsu_addr_ip, lsu_wdata_ip,
        output mem_gnt_ip, mem_rvalid_ip, mem_rdata_ip,
        input  if_gnt_op, if_rvalid_op, if_rdata_op,
        input  lsu_gnt_op, lsu_rvalid_op, lsu_rdata_op,
        input  mem_req_op, mem_we_op, mem_operator_op, mem_addr_op, mem_wdata_op
    );

endinterface

// File: rtl/arb_streak_counter.sv
// rtl/arb_streak_counter.sv - saturating count of back-to-back LSU wins over a waiting fetch
module arb_streak_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_COUNT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);
    logic [STREAK_W-1:0] r_count;
    logic                w_at_limit;

    assign w_at_limit = (r_count >= STREAK_W'(MAX_COUNT));
    assign o_at_limit = w_at_limit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_limit) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding DRAM arbiter between fetch and load/store
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    arb_state_e          r_state;
    arb_owner_e          r_owner;
    logic                r_drop;
    logic                r_mem_req;
    logic                r_mem_we;
    load_store_func_code r_mem_op;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;

    logic w_grant_if;
    logic w_grant_lsu;
    logic w_at_limit;
    logic w_resp;
    logic w_if_resp;
    logic w_lsu_resp;
    logic w_if_flush;

    // Grants are combinational, so they are masked while reset is low.
    always_comb begin
        w_grant_if  = 1'b0;
        w_grant_lsu = 1'b0;
        if (r_state == ARB_IDLE && reset) begin
            if (bus.lsu_req_ip && !w_at_limit) begin
                w_grant_lsu = 1'b1;
            end else if (bus.if_req_ip) begin
                w_grant_if = 1'b1;
            end else if (bus.lsu_req_ip) begin
                w_grant_lsu = 1'b1;
            end
        end
    end

    arb_streak_counter #(
        .MAX_COUNT (MAX_LSU_STREAK)
    ) u_streak (
        .clk        (clock),
        .rst_n      (reset),
        .i_inc      (w_grant_lsu && bus.if_req_ip),
        .i_clr      (w_grant_if || (w_grant_lsu && !bus.if_req_ip)),
        .o_at_limit (w_at_limit)
    );

    assign w_resp     = (r_state == ARB_WAIT) && bus.mem_rvalid_ip;
    assign w_if_resp  = w_resp && (r_owner == OWN_IF);
    assign w_lsu_resp = w_resp && (r_owner == OWN_LSU);
    assign w_if_flush = bus.flush_ip && (r_owner == OWN_IF);

    assign bus.if_gnt_op       = w_grant_if;
    assign bus.lsu_gnt_op      = w_grant_lsu;
    assign bus.if_rvalid_op    = w_if_resp && !(r_drop || bus.flush_ip);
    assign bus.lsu_rvalid_op   = w_lsu_resp;
    assign bus.if_rdata_op     = w_if_resp  ? bus.mem_rdata_ip : '0;
    assign bus.lsu_rdata_op    = w_lsu_resp ? bus.mem_rdata_ip : '0;
    assign bus.mem_req_op      = r_mem_req;
    assign bus.mem_we_op       = r_mem_we;
    assign bus.mem_operator_op = r_mem_op;
    assign bus.mem_addr_op     = r_mem_addr;
    assign bus.mem_wdata_op    = r_mem_wdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ARB_IDLE;
            r_owner     <= OWN_NONE;
            r_drop      <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_op    <= LSF_DEFAULT;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_lsu) begin
                        r_state     <= ARB_ISSUE;
                        r_owner     <= OWN_LSU;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.lsu_we_ip;
                        r_mem_op    <= bus.lsu_operator_ip;
                        r_mem_addr  <= bus.lsu_addr_ip;
                        r_mem_wdata <= bus.lsu_wdata_ip;
                    end else if (w_grant_if) begin
                        r_state     <= ARB_ISSUE;
                        r_owner     <= OWN_IF;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_op    <= LSF_LW;
                        r_mem_addr  <= bus.if_addr_ip;
                        r_mem_wdata <= '0;
                    end
                end
                ARB_ISSUE: begin
                    if (w_if_flush) begin
                        r_drop <= 1'b1;
                    end
                    if (bus.mem_gnt_ip) begin
                        r_state   <= ARB_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                ARB_WAIT: begin
                    if (bus.mem_rvalid_ip) begin
                        r_state <= ARB_IDLE;
                        r_owner <= OWN_NONE;
                        r_drop  <= 1'b0;
                    end else if (w_if_flush) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ARB_IDLE;
                    r_owner   <= OWN_NONE;
                    r_drop    <= 1'b0;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .MAX_LSU_STREAK (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle_inputs();
        bus.if_req_ip       = 1'b0;
        bus.if_addr_ip      = '0;
        bus.flush_ip        = 1'b0;
        bus.lsu_req_ip      = 1'b0;
        bus.lsu_we_ip       = 1'b0;
        bus.lsu_operator_ip = LSF_LW;
        bus.lsu_addr_ip     = '0;
        bus.lsu_wdata_ip    = '0;
        bus.mem_gnt_ip      = 1'b1;
        bus.mem_rvalid_ip   = 1'b0;
        bus.mem_rdata_ip    = '0;
    endtask

    // Inputs change just after the falling edge; observation follows 1ns later.
    task automatic next_cycle();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        bus.if_req_ip  = 1'b1;
        bus.lsu_req_ip = 1'b1;
        next_cycle(); #1;
        checks++; if (bus.if_gnt_op !== 1'b0 || bus.lsu_gnt_op !== 1'b0) begin errors++; $display("FAIL reset_gnt got if=%b lsu=%b exp 0 0", bus.if_gnt_op, bus.lsu_gnt_op); end
        checks++; if (bus.mem_req_op !== 1'b0 || bus.mem_we_op !== 1'b0) begin errors++; $display("FAIL reset_mem_req got req=%b we=%b exp 0 0", bus.mem_req_op, bus.mem_we_op); end
        checks++; if (bus.mem_addr_op !== 32'h0 || bus.mem_wdata_op !== 32'h0) begin errors++; $display("FAIL reset_mem_fields got addr=%h wdata=%h exp 0 0", bus.mem_addr_op, bus.mem_wdata_op); end
        checks++; if (bus.mem_operator_op !== LSF_LW) begin errors++; $display("FAIL reset_operator got %0d exp %0d", bus.mem_operator_op, LSF_LW); end
        checks++; if (bus.if_rvalid_op !== 1'b0 || bus.lsu_rvalid_op !== 1'b0 || bus.if_rdata_op !== 32'h0 || bus.lsu_rdata_op !== 32'h0) begin errors++; $display("FAIL reset_resp got ifv=%b lsuv=%b ifd=%h lsud=%h exp all 0", bus.if_rvalid_op, bus.lsu_rvalid_op, bus.if_rdata_op, bus.lsu_rdata_op); end
        next_cycle();
        idle_inputs();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_lone_fetch();
        next_cycle();
        bus.if_req_ip  = 1'b1;
        bus.if_addr_ip = 32'h10;
        #1;
        checks++; if (bus.if_gnt_op !== 1'b1 || bus.lsu_gnt_op !== 1'b0) begin errors++; $display("FAIL fetch_gnt got if=%b lsu=%b exp 1 0", bus.if_gnt_op, bus.lsu_gnt_op); end
        next_cycle();
        bus.if_req_ip = 1'b0;
        #1;
        checks++; if (bus.mem_req_op !== 1'b1 || bus.mem_addr_op !== 32'h10 || bus.mem_we_op !== 1'b0) begin errors++; $display("FAIL fetch_cmd got req=%b addr=%h we=%b exp 1 10 0", bus.mem_req_op, bus.mem_addr_op, bus.mem_we_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'h00500093;
        #1;
        checks++; if (bus.if_rvalid_op !== 1'b1 || bus.if_rdata_op !== 32'h00500093) begin errors++; $display("FAIL fetch_resp got v=%b d=%h exp 1 00500093", bus.if_rvalid_op, bus.if_rdata_op); end
        checks++; if (bus.lsu_rvalid_op !== 1'b0 || bus.mem_req_op !== 1'b0) begin errors++; $display("FAIL fetch_resp_side got lsuv=%b req=%b exp 0 0", bus.lsu_rvalid_op, bus.mem_req_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        #1;
        checks++; if (bus.if_rvalid_op !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", bus.if_rvalid_op); end
    endtask

    task automatic test_simultaneous();
        next_cycle();
        bus.if_req_ip       = 1'b1;
        bus.if_addr_ip      = 32'h20;
        bus.lsu_req_ip      = 1'b1;
        bus.lsu_we_ip       = 1'b0;
        bus.lsu_operator_ip = LSF_LW;
        bus.lsu_addr_ip     = 32'h200;
        #1;
        checks++; if (bus.lsu_gnt_op !== 1'b1 || bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL simul_first_gnt got if=%b lsu=%b exp 0 1", bus.if_gnt_op, bus.lsu_gnt_op); end
        next_cycle();
        bus.lsu_req_ip = 1'b0;
        #1;
        checks++; if (bus.mem_addr_op !== 32'h200 || bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL simul_lsu_cmd got addr=%h ifg=%b exp 200 0", bus.mem_addr_op, bus.if_gnt_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'h11112222;
        #1;
        checks++; if (bus.lsu_rvalid_op !== 1'b1 || bus.lsu_rdata_op !== 32'h11112222 || bus.if_rvalid_op !== 1'b0) begin errors++; $display("FAIL simul_lsu_resp got lsuv=%b d=%h ifv=%b exp 1 11112222 0", bus.lsu_rvalid_op, bus.lsu_rdata_op, bus.if_rvalid_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        #1;
        checks++; if (bus.if_gnt_op !== 1'b1 || bus.lsu_gnt_op !== 1'b0) begin errors++; $display("FAIL simul_second_gnt got if=%b lsu=%b exp 1 0", bus.if_gnt_op, bus.lsu_gnt_op); end
        next_cycle();
        bus.if_req_ip = 1'b0;
        #1;
        checks++; if (bus.mem_addr_op !== 32'h20) begin errors++; $display("FAIL simul_if_cmd got %h exp 20", bus.mem_addr_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'h33334444;
        #1;
        checks++; if (bus.if_rvalid_op !== 1'b1 || bus.if_rdata_op !== 32'h33334444 || bus.lsu_rvalid_op !== 1'b0) begin errors++; $display("FAIL simul_if_resp got ifv=%b d=%h lsuv=%b exp 1 33334444 0", bus.if_rvalid_op, bus.if_rdata_op, bus.lsu_rvalid_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        #1;
    endtask

    task automatic test_starvation();
        logic exp_if;
        for (int g = 0; g < 6; g++) begin
            exp_if = (g == 4);
            next_cycle();
            bus.mem_rvalid_ip = 1'b0;
            if (g == 0) begin
                bus.if_req_ip   = 1'b1;
                bus.if_addr_ip  = 32'h80;
                bus.lsu_req_ip  = 1'b1;
                bus.lsu_we_ip   = 1'b0;
                bus.lsu_addr_ip = 32'h400;
            end
            #1;
            checks++; if (bus.if_gnt_op !== exp_if || bus.lsu_gnt_op !== !exp_if) begin errors++; $display("FAIL starve_gnt_%0d got if=%b lsu=%b exp %b %b", g, bus.if_gnt_op, bus.lsu_gnt_op, exp_if, !exp_if); end
            next_cycle();
            if (exp_if) bus.if_req_ip = 1'b0;
            next_cycle();
            bus.mem_rvalid_ip = 1'b1;
            bus.mem_rdata_ip  = 32'(g);
            #1;
            checks++; if (bus.if_rvalid_op !== exp_if || bus.lsu_rvalid_op !== !exp_if) begin errors++; $display("FAIL starve_resp_%0d got ifv=%b lsuv=%b exp %b %b", g, bus.if_rvalid_op, bus.lsu_rvalid_op, exp_if, !exp_if); end
        end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        bus.lsu_req_ip    = 1'b0;
        #1;
    endtask

    task automatic test_flush();
        next_cycle();
        bus.if_req_ip  = 1'b1;
        bus.if_addr_ip = 32'h40;
        #1;
        checks++; if (bus.if_gnt_op !== 1'b1) begin errors++; $display("FAIL flush_gnt got %b exp 1", bus.if_gnt_op); end
        next_cycle();
        bus.if_req_ip = 1'b0;
        next_cycle();
        bus.flush_ip = 1'b1;
        #1;
        checks++; if (bus.if_rvalid_op !== 1'b0) begin errors++; $display("FAIL flush_wait got %b exp 0", bus.if_rvalid_op); end
        next_cycle();
        bus.flush_ip      = 1'b0;
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'hAAAA5555;
        #1;
        checks++; if (bus.if_rvalid_op !== 1'b0 || bus.lsu_rvalid_op !== 1'b0) begin errors++; $display("FAIL flush_drop got ifv=%b lsuv=%b exp 0 0", bus.if_rvalid_op, bus.lsu_rvalid_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        bus.if_req_ip     = 1'b1;
        bus.if_addr_ip    = 32'h44;
        #1;
        checks++; if (bus.if_gnt_op !== 1'b1) begin errors++; $display("FAIL flush_idle_gnt got %b exp 1", bus.if_gnt_op); end
        next_cycle();
        bus.if_req_ip = 1'b0;
        next_cycle();
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'h12345678;
        #1;
        checks++; if (bus.if_rvalid_op !== 1'b1 || bus.if_rdata_op !== 32'h12345678) begin errors++; $display("FAIL flush_cleared got v=%b d=%h exp 1 12345678", bus.if_rvalid_op, bus.if_rdata_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        bus.if_req_ip     = 1'b1;
        bus.if_addr_ip    = 32'h48;
        next_cycle();
        bus.if_req_ip = 1'b0;
        next_cycle();
        bus.flush_ip      = 1'b1;
        bus.mem_rvalid_ip = 1'b1;
        #1;
        checks++; if (bus.if_rvalid_op !== 1'b0) begin errors++; $display("FAIL flush_same_cycle got %b exp 0", bus.if_rvalid_op); end
        next_cycle();
        bus.flush_ip      = 1'b0;
        bus.mem_rvalid_ip = 1'b0;
        #1;
    endtask

    task automatic test_store_backpressure();
        next_cycle();
        bus.mem_gnt_ip      = 1'b0;
        bus.lsu_req_ip      = 1'b1;
        bus.lsu_we_ip       = 1'b1;
        bus.lsu_operator_ip = LSF_SW;
        bus.lsu_addr_ip     = 32'h180;
        bus.lsu_wdata_ip    = 32'hDEADBEEF;
        #1;
        checks++; if (bus.lsu_gnt_op !== 1'b1) begin errors++; $display("FAIL store_gnt got %b exp 1", bus.lsu_gnt_op); end
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            bus.lsu_req_ip    = 1'b0;
            bus.lsu_wdata_ip  = 32'h0;
            bus.mem_rvalid_ip = (c == 1);
            #1;
            checks++; if (bus.mem_req_op !== 1'b1 || bus.mem_we_op !== 1'b1 || bus.mem_addr_op !== 32'h180 || bus.mem_wdata_op !== 32'hDEADBEEF || bus.mem_operator_op !== LSF_SW) begin errors++; $display("FAIL store_hold_%0d got req=%b we=%b addr=%h wdata=%h op=%0d exp 1 1 180 deadbeef 7", c, bus.mem_req_op, bus.mem_we_op, bus.mem_addr_op, bus.mem_wdata_op, bus.mem_operator_op); end
            checks++; if (bus.lsu_rvalid_op !== 1'b0) begin errors++; $display("FAIL store_early_resp_%0d got %b exp 0", c, bus.lsu_rvalid_op); end
        end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        bus.mem_gnt_ip    = 1'b1;
        #1;
        checks++; if (bus.mem_req_op !== 1'b1) begin errors++; $display("FAIL store_accept got %b exp 1", bus.mem_req_op); end
        next_cycle();
        #1;
        checks++; if (bus.mem_req_op !== 1'b0 || bus.lsu_rvalid_op !== 1'b0) begin errors++; $display("FAIL store_wait got req=%b v=%b exp 0 0", bus.mem_req_op, bus.lsu_rvalid_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b1;
        #1;
        checks++; if (bus.lsu_rvalid_op !== 1'b1 || bus.if_rvalid_op !== 1'b0) begin errors++; $display("FAIL store_ack got lsuv=%b ifv=%b exp 1 0", bus.lsu_rvalid_op, bus.if_rvalid_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        #1;
        checks++; if (bus.lsu_rvalid_op !== 1'b0) begin errors++; $display("FAIL store_single_pulse got %b exp 0", bus.lsu_rvalid_op); end
    endtask

    task automatic test_mid_reset();
        next_cycle();
        bus.lsu_req_ip      = 1'b1;
        bus.lsu_we_ip       = 1'b0;
        bus.lsu_operator_ip = LSF_LH;
        bus.lsu_addr_ip     = 32'h300;
        next_cycle();
        bus.lsu_req_ip = 1'b0;
        next_cycle();
        #1;
        reset = 1'b0;
        #1;
        checks++; if (bus.mem_addr_op !== 32'h0 || bus.mem_operator_op !== LSF_LW || bus.mem_req_op !== 1'b0) begin errors++; $display("FAIL midrst_async got addr=%h op=%0d req=%b exp 0 2 0", bus.mem_addr_op, bus.mem_operator_op, bus.mem_req_op); end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        bus.mem_rvalid_ip = 1'b1;
        bus.mem_rdata_ip  = 32'h00000BAD;
        #1;
        checks++; if (bus.lsu_rvalid_op !== 1'b0 || bus.if_rvalid_op !== 1'b0 || bus.lsu_rdata_op !== 32'h0) begin errors++; $display("FAIL midrst_stale got lsuv=%b ifv=%b d=%h exp 0 0 0", bus.lsu_rvalid_op, bus.if_rvalid_op, bus.lsu_rdata_op); end
        next_cycle();
        bus.mem_rvalid_ip = 1'b0;
        #1;
        checks++; if (bus.mem_req_op !== 1'b0 || bus.lsu_gnt_op !== 1'b0 || bus.if_gnt_op !== 1'b0) begin errors++; $display("FAIL midrst_idle got req=%b lg=%b ig=%b exp 0 0 0", bus.mem_req_op, bus.lsu_gnt_op, bus.if_gnt_op); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lone_fetch();
        test_simultaneous();
        test_starvation();
        test_flush();
        test_store_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port arbiter between the instruction fetch path and the load/store path in front of the shared main memory (DRAM) of the 5-stage RISC-V core. It selects one requester per transaction and issues exactly one outstanding DRAM access at a time. Each read response or write acknowledge is routed back to the requester that owns the transaction. Data accesses have priority, and a starvation counter guarantees that fetch makes forward progress. On a flush, an in-flight fetch response is discarded.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and DRAM
- DATA_W, 32, read/write data width
- MAX_LSU_STREAK, 4, maximum consecutive LSU grants while a fetch request waits; range 1–15

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; state is cleared immediately when low
- if_req_ip  in  1  fetch request
- if_addr_ip  in  ADDR_W  fetch address
- if_gnt_op  out  1  fetch request captured in this cycle
- if_rvalid_op  out  1  fetch data valid, one-cycle pulse
- if_rdata_op  out  DATA_W  fetch data
- flush_ip  in  1  discard any outstanding fetch response
- lsu_req_ip  in  1  load/store request
- lsu_we_ip  in  1  1 = store, 0 = load
- lsu_operator_ip  in  load_store_func_code  access size and sign
- lsu_addr_ip  in  ADDR_W  data address
- lsu_wdata_ip  in  DATA_W  store data
- lsu_gnt_op  out  1  LSU request captured in this cycle
- lsu_rvalid_op  out  1  load data valid or store acknowledge, one-cycle pulse
- lsu_rdata_op  out  DATA_W  load data
- mem_req_op  out  1  DRAM command valid
- mem_we_op, mem_operator_op, mem_addr_op, mem_wdata_op  out  registered command fields
- mem_gnt_ip  in  1  DRAM accepted the command
- mem_rvalid_ip  in  1  DRAM response valid
- mem_rdata_ip  in  DATA_W  DRAM read data

## Operation
- FSM states: ARB_IDLE, ARB_ISSUE, ARB_WAIT. The owner register holds OWN_NONE, OWN_IF or OWN_LSU.
- **ARB_IDLE.** Winner selection is combinational:
  - LSU wins if lsu_req_ip=1 and streak < MAX_LSU_STREAK.
  - Otherwise IF wins if if_req_ip=1.
  - Otherwise LSU wins if lsu_req_ip=1 (this covers the streak limit being hit with no IF request).
  - The winner's gnt_op is asserted combinationally. At the clock edge the command fields and owner are captured and the FSM moves to ARB_ISSUE.
- Streak counter:
  - Increments on an LSU grant while if_req_ip=1, saturating at MAX_LSU_STREAK.
  - Clears on an IF grant, or on an LSU grant while if_req_ip=0.
- **ARB_ISSUE.** mem_req_op=1 with stable command fields. When mem_gnt_ip=1, the FSM moves to ARB_WAIT. mem_rvalid_ip is ignored in this state.
- **ARB_WAIT.** When mem_rvalid_ip=1:
  - mem_rdata_ip is routed combinationally to the owner's rdata_op.
  - The owner's rvalid_op pulses, unless the owner is IF and the drop flag is set.
  - The FSM returns to ARB_IDLE and owner becomes OWN_NONE.
- Drop flag:
  - Set when flush_ip=1 while the owner is IF in ARB_ISSUE or ARB_WAIT, including in the same cycle as mem_rvalid_ip.
  - Cleared on entry to ARB_IDLE.
  - flush_ip has no effect on an LSU-owned transaction or in ARB_IDLE.
- Requesters may drop req after their gnt pulse. Requests that are not granted must stay asserted and stable.
- Stores complete the same way as loads: the owner receives lsu_rvalid_op, and lsu_rdata_op is don't-care.

## Timing
- Reset (reset=0, asynchronous) forces:
  - ARB_IDLE, OWN_NONE, streak=0, drop=0.
  - mem_req_op=0, mem_we_op=0, mem_addr_op=0, mem_wdata_op=0, mem_operator_op = the package default.
  - All gnt/rvalid outputs 0 and all rdata outputs 0.
- Reset asserted mid-transaction abandons the transaction. No response is delivered after reset is released, even if DRAM later asserts mem_rvalid_ip; the arbiter is in ARB_IDLE and ignores it.
- Minimum latency with mem_gnt_ip tied high and DRAM responding one cycle after acceptance:
  - Cycle 0: req asserted, gnt_op=1.
  - Cycle 1: mem_req_op=1.
  - Cycle 2: mem_rvalid_ip=1 and rvalid_op=1.
  - Cycle 3: ARB_IDLE, next grant possible.
- Throughput is one transaction per 3 cycles at best.
- if_gnt_op and lsu_gnt_op are never both 1 in the same cycle. Likewise if_rvalid_op and lsu_rvalid_op are never both 1.
- mem_req_op is driven only in ARB_ISSUE and is glitch-free.

## Structure
- CORE_PKG additions:
  - arb_state_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}
  - arb_owner_e {OWN_NONE, OWN_IF, OWN_LSU}
  - the default load_store_func_code value used at reset
- Reuses the existing load_store_func_code type.
- One sub-module, arb_streak_counter: a saturating counter with inc/clr inputs and an at_limit output.

## Test plan
- Lone fetch: if_req_ip=1 with address 0x10, DRAM returns 0x00500093 -> if_gnt_op at cycle 0, mem_addr_op=0x10 at cycle 1, if_rvalid_op=1 with if_rdata_op=0x00500093 at cycle 2.
- Simultaneous requests: if_req_ip=1 (address 0x20) and lsu_req_ip=1 (load, address 0x200) -> LSU is granted first, IF is granted on the next ARB_IDLE cycle, and responses go to the correct owners.
- Starvation limit: lsu_req_ip held high for 6 loads with if_req_ip=1 and MAX_LSU_STREAK=4 -> LSU, LSU, LSU, LSU, IF, LSU grant order.
- Flush: IF owns the transaction, flush_ip pulses in ARB_WAIT, then DRAM responds -> if_rvalid_op stays 0 and the FSM returns to ARB_IDLE.
- Store with back-pressure: store of 0xDEADBEEF to address 0x180 with mem_gnt_ip low for 3 cycles -> command fields hold stable until accepted, followed by a single lsu_rvalid_op pulse.
- Mid-transaction reset: reset=0 during ARB_WAIT, then released and a stale mem_rvalid_ip pulse is driven -> all outputs 0 and no rvalid pulse on either side.
